// File: rtl/lz_pkg.sv
// Shared types for the leading-zero normalize/denormalize path: FSM states and
// the count-port width helper used by both the counter and the denormalizer.
package lz_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } lz_state_e;

    // Width of a leading-zero count able to represent 0..width inclusive.
    function automatic int count_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/lz_denormalizer.sv
// Sequential de-normalizer: shifts a normalized word right by its leading-zero
// count, one bit per cycle. Optional sticky output enabled by LZD_STICKY_EN.
module lz_denormalizer
    import lz_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [WIDTH-1:0]                in_data,
    input  logic [count_width(WIDTH)-1:0]   in_count,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [WIDTH-1:0]                out_data,
`ifdef LZD_STICKY_EN
    output logic                            sticky,
`endif
    output logic [1:0]                      state_dbg
);

    // Handshake: a word moves on any rising edge where valid and ready are both
    // high; out_valid stays high with stable data until out_ready is seen.

    localparam int CW = count_width(WIDTH);
    localparam logic [CW-1:0] W_CNT = CW'(WIDTH);

    lz_state_e      state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CW-1:0]  rem_q, rem_d;
    logic [CW-1:0]  clamped;

`ifdef LZD_STICKY_EN
    logic           sticky_q, sticky_d;
    assign sticky = sticky_q;
`endif

    // Counts past the word width all shift everything out.
    assign clamped   = (in_count > W_CNT) ? W_CNT : in_count;
    assign out_data  = data_q;
    assign state_dbg = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            data_q   <= '0;
            rem_q    <= '0;
`ifdef LZD_STICKY_EN
            sticky_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            rem_q    <= rem_d;
`ifdef LZD_STICKY_EN
            sticky_q <= sticky_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        rem_d     = rem_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
`ifdef LZD_STICKY_EN
        sticky_d  = sticky_q;
`endif
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    data_d  = in_data;
                    rem_d   = clamped;
`ifdef LZD_STICKY_EN
                    sticky_d = 1'b0;
`endif
                    state_d = (clamped == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                data_d = data_q >> 1;
                rem_d  = rem_q - CW'(1);
`ifdef LZD_STICKY_EN
                sticky_d = sticky_q | data_q[0];
`endif
                if (rem_q == CW'(1)) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_lz_denormalizer.sv
// Self-checking bench for lz_denormalizer (WIDTH=8): cycle-level behavioural
// model with expected queues, directed literal cases, and random traffic.
module tb_lz_denormalizer;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic [CW-1:0] in_count = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_data;
    logic [1:0]    state_dbg;
`ifdef LZD_STICKY_EN
    logic          sticky;
`endif

    lz_denormalizer #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_count  (in_count),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef LZD_STICKY_EN
        .sticky    (sticky),
`endif
        .state_dbg (state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard / model ----------------
    int n_cmp = 0;
    int n_bad = 0;

    logic [W-1:0] exp_q[$];
    logic         exps_q[$];
    bit           m_busy  = 1'b0;
    bit           m_valid = 1'b0;
    int           m_left  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        exps_q.delete();
        m_busy  = 1'b0;
        m_valid = 1'b0;
        m_left  = 0;
    endtask

    // Advances the model across the coming rising edge using the driven inputs.
    task automatic model_update();
        int n;
        logic [31:0] mask;
        if (!m_busy) begin
            if (in_valid) begin
                n = (int'(in_count) > W) ? W : int'(in_count);
                mask = (32'd1 << n) - 32'd1;
                exp_q.push_back(W'({24'd0, in_data} >> n));
                exps_q.push_back(|({24'd0, in_data} & mask));
                m_busy  = 1'b1;
                m_left  = n;
                m_valid = (n == 0);
            end
        end else if (!m_valid) begin
            m_left--;
            if (m_left == 0) m_valid = 1'b1;
        end else if (out_ready) begin
            m_busy  = 1'b0;
            m_valid = 1'b0;
            void'(exp_q.pop_front());
            void'(exps_q.pop_front());
        end
    endtask

    task automatic check_outputs();
        chk("in_ready", {31'd0, in_ready}, {31'd0, !m_busy});
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        if (m_valid && exp_q.size() > 0) begin
            chk("out_data", {24'd0, out_data}, {24'd0, exp_q[0]});
`ifdef LZD_STICKY_EN
            chk("sticky", {31'd0, sticky}, {31'd0, exps_q[0]});
`endif
        end
    endtask

    // ---------------- driver ----------------
    task automatic cycle(input logic iv, input logic [W-1:0] d, input logic [CW-1:0] c,
                         input logic ordy);
        @(negedge clk);
        check_outputs();
        in_valid  = iv;
        in_data   = d;
        in_count  = c;
        out_ready = ordy;
        model_update();
    endtask

    task automatic reset_now(input string name);
        #2;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        chk({name, " out_valid"}, {31'd0, out_valid}, 32'd0);
        chk({name, " out_data"}, {24'd0, out_data}, 32'd0);
        chk({name, " in_ready"}, {31'd0, in_ready}, 32'd1);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic directed(input string name, input logic [W-1:0] d, input logic [CW-1:0] c,
                            input logic [W-1:0] ed, input logic es, input int elat,
                            input int hold);
        int lat;
        lat = 0;
        cycle(1'b1, d, c, 1'b0);
        for (int k = 0; k < 20; k++) begin
            cycle(1'b0, 8'($urandom), 4'($urandom), 1'b0);
            lat++;
            if (out_valid) break;
        end
        chk({name, " latency"}, lat, elat);
        chk({name, " data"}, {24'd0, out_data}, {24'd0, ed});
`ifdef LZD_STICKY_EN
        chk({name, " sticky"}, {31'd0, sticky}, {31'd0, es});
`else
        if (es === 1'bx) $display("note: unexpected x");
`endif
        for (int h = 0; h < hold; h++) cycle(1'b1, 8'($urandom), 4'($urandom), 1'b0);
        cycle(1'b1, 8'($urandom), 4'($urandom_range(0, 8)), 1'b1);
        cycle(1'b0, 8'd0, 4'd0, 1'b0);
        chk({name, " ready after handshake"}, {31'd0, in_ready}, 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [W-1:0] x;
        int lz;

        repeat (3) @(negedge clk);
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset out_data", {24'd0, out_data}, 32'd0);
        chk("reset in_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;

        directed("basic", 8'b1011_0000, 4'd3, 8'b0001_0110, 1'b0, 4, 0);
        directed("zero_cnt", 8'hFF, 4'd0, 8'hFF, 1'b0, 1, 0);
        directed("zero_fill", 8'h81, 4'd1, 8'h40, 1'b1, 2, 0);
        directed("clamp", 8'h80, 4'd12, 8'h00, 1'b1, 9, 0);
        directed("backpressure", 8'hC3, 4'd2, 8'h30, 1'b1, 3, 5);
        directed("round_trip", 8'hA0, 4'd5, 8'h05, 1'b0, 6, 0);

        // Abort in the second SHIFT cycle, then a clean transaction.
        cycle(1'b1, 8'hF0, 4'd6, 1'b0);
        cycle(1'b0, 8'h00, 4'd0, 1'b0);
        cycle(1'b0, 8'h00, 4'd0, 1'b0);
        reset_now("abort");
        directed("after_abort", 8'hF0, 4'd6, 8'h03, 1'b1, 7, 0);

        // Random traffic, with a share of round-trip words (x<<lz(x), lz(x)).
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                x = 8'($urandom_range(1, 255));
                lz = 0;
                while (x[W-1-lz] == 1'b0) lz++;
                cycle($urandom_range(0, 1) == 1, x << lz, 4'(lz), $urandom_range(0, 9) < 6);
            end else begin
                cycle($urandom_range(0, 1) == 1, 8'($urandom), 4'($urandom_range(0, 12)),
                      $urandom_range(0, 9) < 6);
            end
        end

        // Reset mid-stream wherever the random traffic left the block.
        cycle(1'b1, 8'h5A, 4'd4, 1'b0);
        cycle(1'b0, 8'h00, 4'd0, 1'b0);
        reset_now("mid_reset");
        cycle(1'b0, 8'h00, 4'd0, 1'b0);
        chk("post_reset in_ready", {31'd0, in_ready}, 32'd1);
        chk("post_reset out_valid", {31'd0, out_valid}, 32'd0);
        directed("after_reset", 8'h0C, 4'd2, 8'h03, 1'b0, 3, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Hard stop in case a wait never completes.
    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lz_denormalizer.md
# lz_denormalizer

Sequential de-normalizer: the decode side of the leading-zero counter path. It accepts a normalized word plus a leading-zero count and shifts the word right by that count, one bit per cycle, to restore the original unnormalized value. It sits downstream of normalize/compute stages. It uses a valid/ready handshake on both sides, so it drops into streaming datapaths.

## Interface
Parameters:
- WIDTH, 8, data width in bits (≥2).

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  upstream has a word.
- in_ready  output  1  block can accept a word.
- in_data  input  WIDTH  normalized word.
- in_count  input  $clog2(WIDTH)+1  right-shift amount, in the same encoding as the leading-zero counter output.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts the result.
- out_data  output  WIDTH  de-normalized word.
- sticky  output  1  OR of all bits shifted out. Present only with LZD_STICKY_EN.

## Operation
- The FSM has three states: IDLE, SHIFT, DONE.
- **IDLE**
  - in_ready=1 and out_valid=0.
  - On in_valid&&in_ready, capture in_data into the data register.
  - Capture the remaining count as min(in_count, WIDTH).
  - Clear sticky.
  - If the clamped count is 0, go to DONE. Otherwise go to SHIFT.
- **SHIFT**
  - in_ready=0.
  - Each cycle: data <= data>>1 with zero fill, sticky <= sticky | data[0], remaining <= remaining-1.
  - Go to DONE on the cycle remaining transitions 1→0.
- **DONE**
  - out_valid=1; out_data and sticky are held stable.
  - On out_ready, go to IDLE.
  - No same-cycle accept of a new word. in_ready rises the cycle after the output handshake.
- Clamping: in_count > WIDTH is treated as WIDTH. The result is 0 and sticky is the OR of all input bits.
- in_valid and in_data are ignored outside IDLE.
- Round-trip property: for any nonzero x, denormalizing (x<<lz(x), lz(x)) returns x with sticky=0.

## Timing
- Reset (asynchronous assert, synchronous deassert supplied externally):
  - state=IDLE.
  - data, remaining, sticky, out_data = 0.
  - out_valid=0.
  - in_ready=1.
- Latency from the accept edge to out_valid high is N+1 cycles, where N is the clamped count (1 cycle for N=0).
- Throughput is one word per N+2 cycles with no backpressure.
- Reset asserted mid-SHIFT or in DONE aborts immediately: the result is discarded and the block returns to IDLE.
- out_valid, once high, is never withdrawn before out_ready.

## Configuration
- LZD_STICKY_EN:
  - **Defined:** the sticky port and its register exist and behave as described above.
  - **Undefined:** no sticky port and no sticky logic. All other behaviour and timing are identical.

## Structure
- Package lz_pkg holds:
  - the state typedef (IDLE, SHIFT, DONE);
  - a localparam/function for the count width $clog2(WIDTH)+1, shared with the leading-zero counter.
- The block is a single module with no sub-module; the datapath is one shift register and one down-counter.

## Test plan
All scenarios use WIDTH=8.
- **Reset:** rst_n low mid-stream → out_valid=0, out_data=0, in_ready=1; this holds after release.
- **Basic shift:** in_data=8'b1011_0000, in_count=3 → out_data=8'b0001_0110 on the 4th cycle after accept, sticky=0.
- **Zero count and zero fill:**
  - in_data=8'hFF, in_count=0 → out_data=8'hFF one cycle after accept.
  - Then in_data=8'h81, in_count=1 → 8'h40, sticky=1.
- **Clamp:** in_data=8'h80, in_count=12 → out_data=8'h00 after 9 cycles (clamped to 8), sticky=1.
- **Backpressure:** out_ready low for 5 cycles in DONE → out_valid, out_data and sticky stable; in_ready=0; a new in_valid word is not accepted until one cycle after out_ready.
- **Abort:** rst_n pulsed at the 2nd SHIFT cycle of in_count=6 → back to IDLE with outputs 0; the next transaction completes correctly.
